// File: rtl/framebuffer_dbuf_pkg.sv
// Shared constants, state encoding and datapath helpers for the double-buffered LED framebuffer.
// Serialiser and host writer import the same defaults from here.
package framebuffer_dbuf_pkg;

   localparam int c_ledboards = 30;
   localparam int c_channels  = c_ledboards * 32;
   localparam int c_addr_w    = $clog2(c_channels);
   localparam int c_bpc       = 12;
   localparam int c_max_time  = 480;
   localparam int c_time_w    = $clog2(c_max_time);
   localparam int c_bri_w     = 8;

   localparam int c_ram_depth = 2 * c_channels;
   localparam int c_ram_aw    = $clog2(c_ram_depth);
   localparam int c_prod_w    = c_bpc + c_bri_w;
   localparam int c_rd_stages = 2;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // Bank 1 occupies the upper half of the RAM, so the two banks pack with no gap.
   function automatic logic [c_ram_aw-1:0] ram_idx(input logic bank,
                                                   input logic [c_addr_w-1:0] addr);
      return c_ram_aw'(addr) + (bank ? c_ram_aw'(c_channels) : '0);
   endfunction

   // Brightness scale: full-width product, truncated back to channel width.
   function automatic logic [c_bpc-1:0] scale(input logic [c_bpc-1:0]   d,
                                              input logic [c_bri_w-1:0] b);
      logic [c_prod_w-1:0] p;
      p = c_prod_w'(d) * c_prod_w'(b);
      return p[c_prod_w-1:c_bri_w];
   endfunction

endpackage

// File: rtl/framebuffer_dbuf_if.sv
// Host-write, commit/frame handshake and serialiser-read bundle for framebuffer_dbuf.
interface framebuffer_dbuf_if;
   import framebuffer_dbuf_pkg::*;

   logic                i_wen;
   logic [c_addr_w-1:0] i_waddr;
   logic [c_bpc-1:0]    i_wdata;
   logic                o_wready;
   logic                i_commit;
   logic [c_time_w-1:0] i_time;
   logic                i_frame_start;
   logic                i_ren;
   logic [c_addr_w-1:0] i_raddr;
   logic [c_bri_w-1:0]  i_bright;
   logic                o_rvalid;
   logic [c_bpc-1:0]    o_rdata;
   logic [c_time_w-1:0] o_time;
   logic                o_swapped;

   modport master (
      output i_wen, i_waddr, i_wdata, i_commit, i_time, i_frame_start,
             i_ren, i_raddr, i_bright,
      input  o_wready, o_rvalid, o_rdata, o_time, o_swapped
   );

   modport slave (
      input  i_wen, i_waddr, i_wdata, i_commit, i_time, i_frame_start,
             i_ren, i_raddr, i_bright,
      output o_wready, o_rvalid, o_rdata, o_time, o_swapped
   );

endinterface

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM holding both framebuffer banks: one write port, one registered read port.
// No reset on contents or read register so it maps onto block RAM.
module fb_bank_ram #(
   parameter int DEPTH = 1920,
   parameter int AW    = 11,
   parameter int DW    = 12
) (
   input  logic          i_clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered LED framebuffer: host fills the back bank, serialiser reads the scaled front bank,
// banks swap at a serialiser frame boundary once the host has committed.
module framebuffer_dbuf
   import framebuffer_dbuf_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   framebuffer_dbuf_if.slave  bus
);

   state_t              state_q, state_d;
   logic                front_q;
   logic [c_time_w-1:0] time_q;
   logic [c_time_w-1:0] otime_q;
   logic [c_time_w-1:0] swap_time;
   logic                do_swap;
   logic                swapped_q;

   // A commit coinciding with the swap carries the freshest time value.
   always_comb begin
      state_d   = state_q;
      do_swap   = 1'b0;
      swap_time = bus.i_commit ? bus.i_time : time_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_commit) begin
               if (bus.i_frame_start) do_swap = 1'b1;
               else                   state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (bus.i_frame_start) begin
               do_swap = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         front_q   <= 1'b0;
         time_q    <= '0;
         otime_q   <= '0;
         swapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         swapped_q <= do_swap;
         if (bus.i_commit) time_q <= bus.i_time;
         if (do_swap) begin
            front_q <= ~front_q;
            otime_q <= swap_time;
         end
      end
   end

   assign bus.o_wready  = (state_q == ST_IDLE);
   assign bus.o_time    = otime_q;
   assign bus.o_swapped = swapped_q;

   // Write port: back bank is whichever bank is not in front at the write edge.
   logic                waddr_ok, raddr_ok, we;
   logic [c_ram_aw-1:0] wram_idx, rram_idx;
   logic [c_bpc-1:0]    ram_q;

   assign waddr_ok = bus.i_waddr < c_addr_w'(c_channels);
   assign raddr_ok = bus.i_raddr < c_addr_w'(c_channels);
   assign we       = bus.i_wen && bus.o_wready && waddr_ok;
   assign wram_idx = ram_idx(~front_q, bus.i_waddr);
   assign rram_idx = raddr_ok ? ram_idx(front_q, bus.i_raddr) : '0;

   fb_bank_ram #(
      .DEPTH (c_ram_depth),
      .AW    (c_ram_aw),
      .DW    (c_bpc)
   ) u_ram (
      .i_clk (i_clk),
      .we    (we),
      .waddr (wram_idx),
      .wdata (bus.i_wdata),
      .re    (bus.i_ren),
      .raddr (rram_idx),
      .rdata (ram_q)
   );

   // Read pipeline: stage 1 is the RAM access, stage 2 the brightness scaler.
   logic [c_rd_stages:0] vld_pipe;
   logic [c_bri_w-1:0]   bright_q;
   logic                 rd_ok_q;
   logic [c_bpc-1:0]     rdata_q;

   assign vld_pipe[0] = bus.i_ren;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld_pipe[c_rd_stages:1] <= '0;
         bright_q                <= '0;
         rd_ok_q                 <= 1'b0;
         rdata_q                 <= '0;
      end else begin
         vld_pipe[c_rd_stages:1] <= vld_pipe[c_rd_stages-1:0];
         if (bus.i_ren) begin
            bright_q <= bus.i_bright;
            rd_ok_q  <= raddr_ok;
         end
         if (vld_pipe[1]) rdata_q <= rd_ok_q ? scale(ram_q, bright_q) : '0;
      end
   end

   assign bus.o_rvalid = vld_pipe[c_rd_stages];
   assign bus.o_rdata  = rdata_q;

endmodule
